// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the RV32I pipeline.
//   alu_op_e     - 4-bit ALU operation select
//   result_src_e - 2-bit writeback source select
//   F3_*         - branch funct3 encodings
//   XLEN_DEFAULT - default datapath width
package pipeline_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU.
//   alu_control - operation (alu_op_e encoding)
//   a, b        - operands
//   result      - a op b, modulo 2^XLEN; unknown ops give 0
module alu
  import pipeline_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: E stage of the RV32I pipeline and the E/M pipeline register.
//   Inputs : D/E register fields (*E), writeback bypass (RdW/RegWriteW/ResultW),
//            StallM back-pressure from memory.
//   Outputs: PCSrcE/PCTargetE redirect (combinational), StallE load-use
//            stall request, E/M register fields (*M).
// Build option: define FORWARDING_EN for M/W operand bypass and load-use
// stalling; otherwise operands are used raw and StallE is tied low.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN            = XLEN_DEFAULT,
  parameter bit RESET_PC_BUBBLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            JalrE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  input  logic            ALUSrcAE,
  input  logic            ALUSrcBE,
  input  logic [2:0]      BranchTypeE,
  input  logic [XLEN-1:0] rs1_data_E,
  input  logic [XLEN-1:0] rs2_data_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] immExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [4:0]      RdE,
  input  logic [4:0]      RdW,
  input  logic            RegWriteW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM
);

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, src_a, src_b, alu_res, jalr_sum;
  logic            taken;

`ifdef FORWARDING_EN
  // M beats W: it is the younger producer of the same register.
  always_comb begin
    rs1_fwd = rs1_data_E;
    if (ValidM && RegWriteM && RdM != 5'd0 && RdM == Rs1E)  rs1_fwd = ALUResultM;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)       rs1_fwd = ResultW;
    rs2_fwd = rs2_data_E;
    if (ValidM && RegWriteM && RdM != 5'd0 && RdM == Rs2E)  rs2_fwd = ALUResultM;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)       rs2_fwd = ResultW;
  end

  // Load data isn't available until W; rs2 match stalls even if rs2 is unused.
  assign StallE = ValidE && ValidM && (ResultSrcM == RES_LOAD) && (RdM != 5'd0) &&
                  (RdM == Rs1E || RdM == Rs2E);
`else
  logic unused_fwd;
  assign unused_fwd = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultW};
  assign rs1_fwd    = rs1_data_E;
  assign rs2_fwd    = rs2_data_E;
  assign StallE     = 1'b0;
`endif

  assign src_a = ALUSrcAE ? PCE     : rs1_fwd;
  assign src_b = ALUSrcBE ? immExtE : rs2_fwd;

  alu #(.XLEN(XLEN)) u_alu (
    .alu_control (ALUControlE),
    .a           (src_a),
    .b           (src_b),
    .result      (alu_res)
  );

  always_comb begin
    taken = 1'b0;
    case (BranchTypeE)
      F3_BEQ:  taken = (rs1_fwd == rs2_fwd);
      F3_BNE:  taken = (rs1_fwd != rs2_fwd);
      F3_BLT:  taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      F3_BGE:  taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      F3_BLTU: taken = (rs1_fwd <  rs2_fwd);
      F3_BGEU: taken = (rs1_fwd >= rs2_fwd);
      default: taken = 1'b0;
    endcase
  end

  // A redirect must not fire while E is held, or it would fire again on release.
  assign PCSrcE    = ValidE && !StallM && !StallE && (JumpE || (BranchE && taken));
  assign jalr_sum  = rs1_fwd + immExtE;
  assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + immExtE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ValidM     <= !RESET_PC_BUBBLE;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= 5'd0;
    end else if (!StallM) begin
      if (StallE) begin
        // Bubble: only the control bits are cleared, data fields hold.
        ValidM    <= 1'b0;
        RegWriteM <= 1'b0;
        MemWriteM <= 1'b0;
      end else begin
        ValidM     <= ValidE;
        RegWriteM  <= RegWriteE && ValidE;
        MemWriteM  <= MemWriteE && ValidE;
        ResultSrcM <= ResultSrcE;
        ALUResultM <= alu_res;
        WriteDataM <= rs2_fwd;
        PCPlus4M   <= PCPlus4E;
        RdM        <= RdE;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, JalrE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic        ALUSrcAE, ALUSrcBE;
  logic [2:0]  BranchTypeE;
  logic [31:0] rs1_data_E, rs2_data_E, PCE, immExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE, RdW;
  logic        RegWriteW;
  logic [31:0] ResultW;
  logic        StallM;
  logic        PCSrcE, StallE, ValidM, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .JalrE(JalrE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .BranchTypeE(BranchTypeE), .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E),
    .PCE(PCE), .immExtE(immExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdW(RdW), .RegWriteW(RegWriteW), .ResultW(ResultW), .StallM(StallM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE), .ValidM(ValidM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; registered outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ValidE = 0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; JalrE = 0;
    ResultSrcE = 2'b00; ALUControlE = ALU_ADD; ALUSrcAE = 0; ALUSrcBE = 0;
    BranchTypeE = 3'b010; rs1_data_E = 0; rs2_data_E = 0; PCE = 0; immExtE = 0;
    PCPlus4E = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdW = 0; RegWriteW = 0; ResultW = 0;
    StallM = 0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    idle();
    ValidE = 1; RegWriteE = 1; ALUControlE = op; rs1_data_E = a; rs2_data_E = b; RdE = rd;
  endtask

  logic [3:0]  t_op [12];
  logic [31:0] t_a [12], t_b [12], t_exp [12];

  initial begin
    t_op[0]  = ALU_ADD;   t_a[0]  = 32'hFFFFFFFF; t_b[0]  = 32'h1;        t_exp[0]  = 32'h0;
    t_op[1]  = ALU_SUB;   t_a[1]  = 32'd5;        t_b[1]  = 32'd7;        t_exp[1]  = 32'hFFFFFFFE;
    t_op[2]  = ALU_AND;   t_a[2]  = 32'hF0F0;     t_b[2]  = 32'hFF00;     t_exp[2]  = 32'hF000;
    t_op[3]  = ALU_OR;    t_a[3]  = 32'hF0F0;     t_b[3]  = 32'h0F0F;     t_exp[3]  = 32'hFFFF;
    t_op[4]  = ALU_XOR;   t_a[4]  = 32'hFFFF;     t_b[4]  = 32'h00FF;     t_exp[4]  = 32'hFF00;
    t_op[5]  = ALU_SLT;   t_a[5]  = 32'hFFFFFFFF; t_b[5]  = 32'h1;        t_exp[5]  = 32'h1;
    t_op[6]  = ALU_SLTU;  t_a[6]  = 32'hFFFFFFFF; t_b[6]  = 32'h1;        t_exp[6]  = 32'h0;
    t_op[7]  = ALU_SLL;   t_a[7]  = 32'h1;        t_b[7]  = 32'h3F;       t_exp[7]  = 32'h80000000;
    t_op[8]  = ALU_SRL;   t_a[8]  = 32'h80000000; t_b[8]  = 32'h4;        t_exp[8]  = 32'h08000000;
    t_op[9]  = ALU_SRA;   t_a[9]  = 32'h80000000; t_b[9]  = 32'h4;        t_exp[9]  = 32'hF8000000;
    t_op[10] = ALU_PASSB; t_a[10] = 32'h0;        t_b[10] = 32'hABCD;     t_exp[10] = 32'hABCD;
    t_op[11] = 4'hF;      t_a[11] = 32'h1234;     t_b[11] = 32'h5678;     t_exp[11] = 32'h0;

    // Reset
    idle();
    rst = 1;
    tick(); tick();
    chk("rst_validm", {31'b0, ValidM}, 0);
    chk("rst_regwm", {31'b0, RegWriteM}, 0);
    chk("rst_memwm", {31'b0, MemWriteM}, 0);
    chk("rst_ressrc", {30'b0, ResultSrcM}, 0);
    chk("rst_alures", ALUResultM, 0);
    chk("rst_wdata", WriteDataM, 0);
    chk("rst_pc4", PCPlus4M, 0);
    chk("rst_rd", {27'b0, RdM}, 0);
    rst = 0;

    // ADD 5+7
    alu_op(ALU_ADD, 32'd5, 32'd7, 5'd3);
    #1 chk("add_pcsrc", {31'b0, PCSrcE}, 0);
    tick();
    chk("add_res", ALUResultM, 32'd12);
    chk("add_regw", {31'b0, RegWriteM}, 1);
    chk("add_valid", {31'b0, ValidM}, 1);
    chk("add_rd", {27'b0, RdM}, 3);

    // ALU operation table
    for (int i = 0; i < 12; i++) begin
      alu_op(t_op[i], t_a[i], t_b[i], 5'd9);
      tick();
      chk($sformatf("alu_op%0d", i), ALUResultM, t_exp[i]);
    end

    // Branches: BLT signed taken, BLTU not, BEQ taken, 010 never
    idle();
    ValidE = 1; BranchE = 1; BranchTypeE = F3_BLT; ALUControlE = ALU_SUB;
    rs1_data_E = 32'hFFFFFFFF; rs2_data_E = 32'd1; PCE = 32'h100; immExtE = 32'h20;
    #1 chk("blt_pcsrc", {31'b0, PCSrcE}, 1);
    chk("blt_target", PCTargetE, 32'h120);
    BranchTypeE = F3_BLTU;
    #1 chk("bltu_pcsrc", {31'b0, PCSrcE}, 0);
    BranchTypeE = F3_BGEU;
    #1 chk("bgeu_pcsrc", {31'b0, PCSrcE}, 1);
    BranchTypeE = F3_BEQ; rs2_data_E = 32'hFFFFFFFF;
    #1 chk("beq_pcsrc", {31'b0, PCSrcE}, 1);
    BranchTypeE = 3'b010;
    #1 chk("f3_010_pcsrc", {31'b0, PCSrcE}, 0);
    tick();

    // JALR: target bit 0 cleared, link value to M
    idle();
    ValidE = 1; JumpE = 1; JalrE = 1; RegWriteE = 1; ResultSrcE = RES_PC4;
    ALUSrcBE = 1; rs1_data_E = 32'h203; immExtE = 0; PCE = 32'h40; PCPlus4E = 32'h44; RdE = 5'd1;
    #1 chk("jalr_pcsrc", {31'b0, PCSrcE}, 1);
    chk("jalr_target", PCTargetE, 32'h202);
    tick();
    chk("jalr_pc4", PCPlus4M, 32'h44);
    chk("jalr_ressrc", {30'b0, ResultSrcM}, 2);

    // Store: address and store data
    idle();
    ValidE = 1; MemWriteE = 1; ALUSrcBE = 1; rs1_data_E = 32'h10; immExtE = 32'h4;
    rs2_data_E = 32'hDEADBEEF;
    tick();
    chk("st_addr", ALUResultM, 32'h14);
    chk("st_data", WriteDataM, 32'hDEADBEEF);
    chk("st_memw", {31'b0, MemWriteM}, 1);

    // Invalid E: controls gated, no redirect
    idle();
    RegWriteE = 1; MemWriteE = 1; JumpE = 1;
    #1 chk("inv_pcsrc", {31'b0, PCSrcE}, 0);
    tick();
    chk("inv_valid", {31'b0, ValidM}, 0);
    chk("inv_regw", {31'b0, RegWriteM}, 0);
    chk("inv_memw", {31'b0, MemWriteM}, 0);

    // StallM with a taken branch in E: hold, no redirect, then one redirect
    alu_op(ALU_ADD, 32'd1, 32'd1, 5'd7);
    tick();
    chk("pre_hold_res", ALUResultM, 32'd2);
    idle();
    ValidE = 1; BranchE = 1; BranchTypeE = F3_BNE; ALUControlE = ALU_SUB;
    rs1_data_E = 32'hFFFFFFFF; rs2_data_E = 32'd1; PCE = 32'h200; immExtE = 32'h8;
    StallM = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("hold_pcsrc%0d", i), {31'b0, PCSrcE}, 0);
      tick();
      chk($sformatf("hold_res%0d", i), ALUResultM, 32'd2);
      chk($sformatf("hold_rd%0d", i), {27'b0, RdM}, 7);
    end
    StallM = 0;
    #1 chk("rel_pcsrc", {31'b0, PCSrcE}, 1);
    chk("rel_target", PCTargetE, 32'h208);
    tick();
    chk("rel_res", ALUResultM, 32'hFFFFFFFE);
    chk("rel_regw", {31'b0, RegWriteM}, 0);

    // Reset while memory is stalled clears the held register
    StallM = 1; rst = 1;
    tick();
    rst = 0;
    chk("rst_hold_res", ALUResultM, 0);
    chk("rst_hold_valid", {31'b0, ValidM}, 0);

`ifdef FORWARDING_EN
    // Back-to-back dependency, M forward wins over W
    alu_op(ALU_ADD, 32'd5, 32'd7, 5'd3);
    Rs1E = 5'd1; Rs2E = 5'd2;
    tick();
    alu_op(ALU_SUB, 32'h99, 32'h55, 5'd4);
    Rs1E = 5'd3; Rs2E = 5'd3; RdW = 5'd3; RegWriteW = 1; ResultW = 32'h1234;
    #1 chk("fwd_stall", {31'b0, StallE}, 0);
    tick();
    chk("fwd_sub", ALUResultM, 32'd0);
    chk("fwd_wdata", WriteDataM, 32'd12);

    // Load-use: one bubble then W forward
    idle();
    ValidE = 1; RegWriteE = 1; ResultSrcE = RES_LOAD; ALUSrcBE = 1; rs1_data_E = 32'h100;
    RdE = 5'd3; Rs1E = 5'd6;
    tick();
    alu_op(ALU_ADD, 32'h0, 32'd10, 5'd5);
    Rs1E = 5'd3; Rs2E = 5'd1;
    #1 chk("lu_stall", {31'b0, StallE}, 1);
    tick();
    chk("lu_bubble_valid", {31'b0, ValidM}, 0);
    chk("lu_bubble_regw", {31'b0, RegWriteM}, 0);
    chk("lu_stall_clear", {31'b0, StallE}, 0);
    RdW = 5'd3; RegWriteW = 1; ResultW = 32'h50;
    tick();
    chk("lu_res", ALUResultM, 32'h5A);
    chk("lu_valid", {31'b0, ValidM}, 1);
    chk("lu_rd", {27'b0, RdM}, 5);

    // Load-use with StallM: hold, StallE stays up; then reset mid-stall
    idle();
    ValidE = 1; RegWriteE = 1; ResultSrcE = RES_LOAD; ALUSrcBE = 1; rs1_data_E = 32'h80;
    RdE = 5'd3;
    tick();
    alu_op(ALU_ADD, 32'h0, 32'd1, 5'd5);
    Rs1E = 5'd3; StallM = 1;
    tick();
    chk("lu_sm_stall", {31'b0, StallE}, 1);
    chk("lu_sm_hold", ALUResultM, 32'h80);
    rst = 1;
    tick();
    rst = 0; StallM = 0;
    chk("lu_rst_valid", {31'b0, ValidM}, 0);
    chk("lu_rst_res", ALUResultM, 0);
    chk("lu_rst_stall", {31'b0, StallE}, 0);
`else
    // Without forwarding the stall request is never raised
    alu_op(ALU_ADD, 32'h0, 32'd1, 5'd3);
    ResultSrcE = RES_LOAD;
    tick();
    Rs1E = 5'd3;
    #1 chk("nofwd_stall", {31'b0, StallE}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
